// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the ALU subtractor. Beats (difference plus
//   zero flag) pass through a valid/ready handshake. There is one output
//   register and one skid entry. Because of the skid entry, in_ready is driven
//   only from registered state and never from out_ready. The stage also keeps
//   zero-result statistics and a sticky flag-consistency error for debug.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   result_in, flag_in    difference and zero flag from the subtractor
//   out_valid/out_ready   downstream handshake
//   result_out, flag_out  registered beat presented downstream
//   zero_count            saturating count of accepted beats with flag_in=1
//   zero_sticky           set by any accepted beat with flag_in=1
//   flag_err              set when an accepted beat has flag_in != (result_in==0)
//   clr_sticky            synchronous clear of zero_count/zero_sticky/flag_err
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result_in,
  input  logic             flag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic             flag_out,
  output logic [CNT_W-1:0] zero_count,
  output logic             zero_sticky,
  input  logic             clr_sticky,
  output logic             flag_err
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_result;
  logic             skid_flag;
  logic             accept;
  logic             emit;
  logic             out_free;
  logic             mismatch;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;
  // The output register can take a new beat when it is empty or is being
  // emitted in this cycle.
  assign out_free = ~out_valid | emit;
  assign mismatch = flag_in != (result_in == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      result_out  <= '0;
      flag_out    <= 1'b0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_flag   <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        // The skid beat is older, so it goes out first. While the skid entry
        // is full, in_ready is low, so no new beat can arrive in this cycle.
        out_valid  <= 1'b1;
        result_out <= skid_result;
        flag_out   <= skid_flag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        result_out <= result_in;
        flag_out   <= flag_in;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (accept) begin
      skid_valid  <= 1'b1;
      skid_result <= result_in;
      skid_flag   <= flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_count  <= '0;
      zero_sticky <= 1'b0;
      flag_err    <= 1'b0;
    end else if (accept) begin
      // When a beat is accepted in the same cycle as clr_sticky, the beat
      // takes priority. The status bits restart from that beat's values.
      if (clr_sticky) begin
        zero_count  <= flag_in ? CNT_ONE : '0;
        zero_sticky <= flag_in;
        flag_err    <= mismatch;
      end else begin
        if (flag_in && (zero_count != '1)) begin
          zero_count <= zero_count + CNT_ONE;
        end
        if (flag_in) begin
          zero_sticky <= 1'b1;
        end
        if (mismatch) begin
          flag_err <= 1'b1;
        end
      end
    end else if (clr_sticky) begin
      zero_count  <= '0;
      zero_sticky <= 1'b0;
      flag_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result_in;
  logic        flag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  logic        flag_out;
  logic [15:0] zero_count;
  logic        zero_sticky;
  logic        clr_sticky;
  logic        flag_err;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] result_out2;
  logic        flag_out2;
  logic [1:0]  zero_count2;
  logic        zero_sticky2;
  logic        flag_err2;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] q[$];
  logic [32:0] exp_beat;
  int          sent;
  int          rcv;
  logic        acc;
  logic        emt;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .result_in(result_in), .flag_in(flag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_out(result_out), .flag_out(flag_out),
    .zero_count(zero_count), .zero_sticky(zero_sticky),
    .clr_sticky(clr_sticky), .flag_err(flag_err)
  );

  alu_result_stage #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .result_in(result_in), .flag_in(flag_in),
    .out_valid(out_valid2), .out_ready(out_ready),
    .result_out(result_out2), .flag_out(flag_out2),
    .zero_count(zero_count2), .zero_sticky(zero_sticky2),
    .clr_sticky(clr_sticky), .flag_err(flag_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    result_in  = '0;
    flag_in    = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result_out", result_out, 0);
    check("rst_flag_out", flag_out, 0);
    check("rst_zero_count", zero_count, 0);
    check("rst_zero_sticky", zero_sticky, 0);
    check("rst_flag_err", flag_err, 0);
    #10;
    rst_n = 1'b1;
    tick();

    // latency: one cycle from in_valid to out_valid
    out_ready = 1'b1;
    in_valid  = 1'b1;
    result_in = 32'h0000_0005;
    flag_in   = 1'b0;
    tick();
    check("lat_out_valid", out_valid, 1);
    check("lat_result_out", result_out, 32'h5);
    check("lat_flag_out", flag_out, 0);
    in_valid = 1'b0;
    tick();
    check("lat_drained", out_valid, 0);

    // backpressure: A, B buffered, C held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    result_in = 32'h1;
    tick();
    check("bp_a_in_ready", in_ready, 1);
    result_in = 32'h2;
    tick();
    check("bp_skid_full", in_ready, 0);
    result_in = 32'h3;
    tick();
    check("bp_c_held", in_ready, 0);
    check("bp_out_holds_a", result_out, 32'h1);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_no_comb", in_ready, 0);
    tick();
    check("bp_out_b", result_out, 32'h2);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_out_c", result_out, 32'h3);
    check("bp_out_c_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_empty", out_valid, 0);

    // streaming with random backpressure against a queue model
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 2000 && (sent < 100 || q.size() > 0); cyc++) begin
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        in_valid  = 1'b1;
        result_in = $urandom | 32'h1;
        flag_in   = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      check("str_in_ready", in_ready, 32'(q.size() < 2));
      check("str_out_valid", out_valid, 32'(q.size() > 0));
      acc = in_valid & in_ready;
      emt = out_valid & out_ready;
      if (emt) begin
        if (q.size() > 0) exp_beat = q.pop_front();
        else exp_beat = '0;
        check("str_result", result_out, exp_beat[31:0]);
        check("str_flag", flag_out, 32'(exp_beat[32]));
        rcv++;
      end
      if (acc) begin
        q.push_back({flag_in, result_in});
        sent++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("str_received", rcv, 100);
    check("str_no_err", flag_err, 0);
    tick();
    tick();

    // zero statistics and clear-with-accept priority
    in_valid  = 1'b1;
    result_in = 32'h0;
    flag_in   = 1'b1;
    tick();
    tick();
    tick();
    check("zs_count3", zero_count, 3);
    check("zs_sticky", zero_sticky, 1);
    check("zs_no_err", flag_err, 0);
    clr_sticky = 1'b1;
    tick();
    check("zs_clr_accept_count", zero_count, 1);
    check("zs_clr_accept_sticky", zero_sticky, 1);
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
    tick();
    check("zs_idle_hold", zero_count, 1);

    // flag error detection and clear
    in_valid  = 1'b1;
    result_in = 32'h0;
    flag_in   = 1'b0;
    tick();
    check("fe_zero_noflag", flag_err, 1);
    check("fe_count_hold", zero_count, 1);
    in_valid   = 1'b0;
    clr_sticky = 1'b1;
    tick();
    check("fe_cleared", flag_err, 0);
    check("fe_count_cleared", zero_count, 0);
    check("fe_sticky_cleared", zero_sticky, 0);
    clr_sticky = 1'b0;
    in_valid   = 1'b1;
    result_in  = 32'h7;
    flag_in    = 1'b1;
    tick();
    check("fe_nonzero_flag", flag_err, 1);
    in_valid   = 1'b0;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;

    // saturation on the narrow counter
    in_valid  = 1'b1;
    result_in = 32'h0;
    flag_in   = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    tick();
    check("sat_wide_count", zero_count, 5);
    check("sat_narrow_count", zero_count2, 3);
    check("sat_narrow_err", flag_err2, 0);

    // asynchronous reset with two beats buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    result_in = 32'h0;
    flag_in   = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("ar_pre_full", in_ready, 0);
    check("ar_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_zero_count", zero_count, 0);
    check("ar_zero_sticky", zero_sticky, 0);
    check("ar_flag_err", flag_err, 0);
    check("ar_result_out", result_out, 0);
    check("ar_narrow_count", zero_count2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
